fft_bitrev_reorder: RTL and testbench
=====================================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter DW, default 12, meaning sample width of each of the real and imaginary parts.
REQ-002 Parameter LOG2_NMAX, default 10, meaning log2 of the maximum frame length; fftpts width is LOG2_NMAX+1.
REQ-003 Parameter LOG2_NMIN, default 3, meaning log2 of the minimum frame length.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 sink_valid / sink_ready  in / out  1 / 1  Avalon-ST input handshake; a beat is accepted when both are high.
REQ-007 sink_sop, sink_eop  in  1 each  frame delimiters.
REQ-008 sink_error  in  2  upstream error code for the beat.
REQ-009 sink_real, sink_imag  in  DW each  natural-order sample.
REQ-010 fftpts_in  in  LOG2_NMAX+1  frame length, sampled on the sop beat.
REQ-011 source_valid / source_ready  out / in  1 / 1  output handshake.
REQ-012 source_sop, source_eop, source_error  out  1, 1, 2  output delimiters and frame error code.
REQ-013 source_real, source_imag  out  DW each  bit-reversed-order sample.
REQ-014 fftpts_out  out  LOG2_NMAX+1  length of the frame being emitted.

Function
REQ-015 The block SHALL emit each accepted frame of N samples with output index k carrying input index bitrev_L(k), where L = log2(N).
REQ-016 N SHALL be 2^floor(log2(fftpts_in)) at sop, clamped to [2^LOG2_NMIN, 2^LOG2_NMAX]; fftpts_in = 0 gives 2^LOG2_NMIN.
REQ-017 Storage SHALL be two banks of 2^LOG2_NMAX complex entries, ping-pong: one bank is written while the other is read.
REQ-018 sink_ready SHALL be high iff the current write bank is not full; it SHALL NOT depend combinationally on sink_valid.
REQ-019 Write FSM states: IDLE, FILL, DISCARD. IDLE->FILL on an accepted sop beat, which is written at address 0. FILL->IDLE with the bank marked full on the accepted beat that carries eop at count N-1.
REQ-020 In IDLE, an accepted beat without sop SHALL be dropped; error 2'b01 SHALL be latched for the next frame.
REQ-021 In FILL, eop before count N-1 SHALL set error 2'b11, zero-fill the remaining entries logically (read returns 0), and mark the bank full.
REQ-022 In FILL, a beat at count N-1 without eop SHALL set error 2'b10 and mark the bank full; the state SHALL then become DISCARD.
REQ-023 DISCARD SHALL drop beats until the first accepted sop, which starts a new frame as in IDLE.
REQ-024 Any nonzero sink_error within a frame SHALL be ORed into that frame's error, and source_error SHALL carry the frame error on every beat of that frame.
REQ-025 Read FSM states: IDLE, READ. IDLE->READ when the read bank is full. READ->IDLE, freeing the bank and toggling it, when the eop beat is accepted at the source.
REQ-026 First source_valid of a frame SHALL assert no later than 2 cycles after the bank is marked full, given the read bank was idle.
REQ-027 Output SHALL be registered with a skid stage. With source_ready held high, one beat SHALL be emitted per cycle with no bubbles inside a frame.
REQ-028 While source_valid is high and source_ready is low, all source_* outputs and fftpts_out SHALL hold stable.
REQ-029 source_sop SHALL be set on k=0 and source_eop on k=N-1; fftpts_out SHALL equal N for the whole frame.
REQ-030 A write completion and a read completion in the same cycle SHALL both take effect, so that no frame is lost or duplicated.
REQ-031 The sop beat of frame i+1 SHALL be accepted in the cycle after the eop of frame i whenever the other bank is free.

Reset
REQ-032 On reset_n low, both FSMs SHALL go to IDLE, all bank-full flags and latched errors SHALL clear, and the bank pointers SHALL reset to 0.
REQ-033 During and after reset: sink_ready=0 during reset and 1 after the first clock with reset released; source_valid, source_sop, source_eop = 0; source_error, source_real, source_imag, fftpts_out = 0.
REQ-034 A reset in mid-frame SHALL discard all partially written and partially read data; RAM contents need not be cleared.

Structure
REQ-035 A shared package fft_pkg SHALL hold the error code constants (ERR_NONE=00, ERR_MISSING_SOP=01, ERR_MISSING_EOP=10, ERR_UNEXP_EOP=11), the FSM state enums, and a bitrev function parameterised by L.
REQ-036 A single sub-module fft_dpram SHALL provide a simple dual-port RAM (one write port, one registered read port, depth 2^(LOG2_NMAX+1), width 2*DW), instantiated once with the bank index as the address MSB.

Verification
REQ-037 N=8, real=0..7, imag=0, source_ready=1 -> real out 0,4,2,6,1,5,3,7; sop on 0, eop on 7; fftpts_out=8; error 00.
REQ-038 Three back-to-back N=16 frames, source_ready=1 -> 48 output beats in correct bit-reversed order; no frame lost; no bubbles within a frame.
REQ-039 Frame N=8 followed by frame N=1024 -> second frame output k=1 carries input index 512; fftpts_out=1024.
REQ-040 N=16 with random 50% source_ready and sink_valid -> output order matches the golden model; outputs stable while stalled.
REQ-041 N=8 with eop on beat 4 -> 8 output beats, entries 5..7 are 0, source_error=11 on all beats; next valid frame reports 00.
REQ-042 Reset asserted at beat 5 of an N=16 frame, then a fresh N=8 frame -> no stale output; the N=8 frame is emitted correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the bit-reversal reorder buffer.
// Error codes, FSM states, bit reversal and frame-length decode.
package fft_pkg;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_MISSING_SOP = 2'b01;
  localparam logic [1:0] ERR_MISSING_EOP = 2'b10;
  localparam logic [1:0] ERR_UNEXP_EOP   = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DISCARD
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_t;

  // Reverse the low l bits of k (l <= 16).
  function automatic logic [15:0] bitrev(
    input logic [15:0] k,
    input logic [4:0]  l
  );
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = k[i];
    return r >> (5'd16 - l);
  endfunction

  // floor(log2(v)) clamped to [lmin, lmax]; v = 0 gives lmin.
  function automatic logic [4:0] frame_log2(
    input logic [31:0] v,
    input int          lmin,
    input int          lmax
  );
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    if (r < lmin) r = lmin;
    if (r > lmax) r = lmax;
    return 5'(r);
  endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Address MSB selects the ping-pong bank.
module fft_dpram #(
  parameter int AW = 11,
  parameter int W  = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer emitting samples in bit-reversed order.
// Write side fills one bank while the read side drains the other.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DW        = 12,
  parameter int LOG2_NMAX = 10,
  parameter int LOG2_NMIN = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sink_valid,
  output logic                 sink_ready,
  input  logic                 sink_sop,
  input  logic                 sink_eop,
  input  logic [1:0]           sink_error,
  input  logic [DW-1:0]        sink_real,
  input  logic [DW-1:0]        sink_imag,
  input  logic [LOG2_NMAX:0]   fftpts_in,
  output logic                 source_valid,
  input  logic                 source_ready,
  output logic                 source_sop,
  output logic                 source_eop,
  output logic [1:0]           source_error,
  output logic [DW-1:0]        source_real,
  output logic [DW-1:0]        source_imag,
  output logic [LOG2_NMAX:0]   fftpts_out
);

  localparam int AW = LOG2_NMAX;
  localparam int CW = LOG2_NMAX + 1;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [1:0]    err;
    cnt_t          n;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } beat_t;

  wr_state_t  wr_state;
  logic       wr_bank;
  cnt_t       wr_cnt;
  logic [4:0] wr_l;
  logic [1:0] wr_err;
  logic [1:0] pend_err;
  logic       rdy_en;

  logic [1:0] full;
  logic [4:0] bank_l   [2];
  logic [1:0] bank_err [2];
  cnt_t       bank_cnt [2];

  logic       accept;
  logic       start;
  logic       beat;
  logic       last;
  logic       wr_done;
  cnt_t       c;
  cnt_t       n_wr;
  logic [4:0] l;
  logic [4:0] in_l;
  logic [1:0] e;
  logic [1:0] done_err;

  assign sink_ready = rdy_en & ~full[wr_bank];
  assign accept     = sink_valid & sink_ready;
  assign in_l       = frame_log2(32'(fftpts_in), LOG2_NMIN, LOG2_NMAX);
  assign start      = accept & sink_sop & (wr_state != WR_FILL);
  assign beat       = start | (accept & (wr_state == WR_FILL));
  assign c          = start ? '0 : wr_cnt;
  assign l          = start ? in_l : wr_l;
  assign e          = (start ? pend_err : wr_err) | sink_error;
  assign n_wr       = cnt_t'(1) << l;
  assign last       = (c == n_wr - cnt_t'(1));
  assign wr_done    = beat & (sink_eop | last);
  assign done_err   = e | (sink_eop ? (last ? ERR_NONE : ERR_UNEXP_EOP)
                                    : ERR_MISSING_EOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= WR_IDLE;
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      wr_l     <= '0;
      wr_err   <= ERR_NONE;
      pend_err <= ERR_NONE;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (beat) begin
        wr_cnt <= c + cnt_t'(1);
        wr_l   <= l;
        wr_err <= e;
        if (!wr_done)
          wr_state <= WR_FILL;
        else if (last && !sink_eop)
          wr_state <= WR_DISCARD;
        else
          wr_state <= WR_IDLE;
      end
      if (wr_done) wr_bank <= ~wr_bank;
      if (start)
        pend_err <= ERR_NONE;
      else if (accept && wr_state == WR_IDLE)
        pend_err <= pend_err | ERR_MISSING_SOP;
    end
  end

  rd_state_t  rd_state;
  logic       rd_bank;
  cnt_t       rd_k;
  cnt_t       rd_n;
  cnt_t       k;
  logic [AW-1:0] rev_idx;
  logic [1:0] occ;
  logic       want;
  logic       issue;
  logic       pop;
  logic       rd_done;

  logic       p1_v;
  logic       p1_sop;
  logic       p1_eop;
  logic       p1_zero;
  logic [1:0] p1_err;
  cnt_t       p1_n;
  logic [2*DW-1:0] rdata;
  beat_t      p1_beat;

  beat_t      out_q;
  beat_t      skid_q;
  logic       out_v;
  logic       skid_v;

  // Banks are always released in fill order, so one flag pair suffices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0;
      for (int b = 0; b < 2; b++) begin
        bank_l[b]   <= '0;
        bank_err[b] <= ERR_NONE;
        bank_cnt[b] <= '0;
      end
    end else begin
      if (rd_done) full[rd_bank] <= 1'b0;
      if (wr_done) begin
        full[wr_bank]     <= 1'b1;
        bank_l[wr_bank]   <= l;
        bank_err[wr_bank] <= done_err;
        bank_cnt[wr_bank] <= c + cnt_t'(1);
      end
    end
  end

  assign rd_n    = cnt_t'(1) << bank_l[rd_bank];
  assign k       = (rd_state == RD_IDLE) ? '0 : rd_k;
  assign rev_idx = AW'(bitrev(16'(k), bank_l[rd_bank]));
  assign pop     = out_v & source_ready;
  assign occ     = 2'(p1_v) + 2'(out_v) + 2'(skid_v) - 2'(pop);
  assign want    = (rd_state == RD_IDLE) ? full[rd_bank] : (rd_k != rd_n);
  assign issue   = want & (occ < 2'd2);
  assign rd_done = pop & out_q.eop;

  fft_dpram #(
    .AW (AW + 1),
    .W  (2 * DW)
  ) u_ram (
    .clk   (clk),
    .we    (beat),
    .waddr ({wr_bank, c[AW-1:0]}),
    .wdata ({sink_real, sink_imag}),
    .raddr ({rd_bank, rev_idx}),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_k     <= '0;
      p1_v     <= 1'b0;
      p1_sop   <= 1'b0;
      p1_eop   <= 1'b0;
      p1_zero  <= 1'b0;
      p1_err   <= ERR_NONE;
      p1_n     <= '0;
    end else begin
      p1_v <= issue;
      if (issue) begin
        p1_sop  <= (k == '0);
        p1_eop  <= (k == rd_n - cnt_t'(1));
        p1_zero <= (cnt_t'(rev_idx) >= bank_cnt[rd_bank]);
        p1_err  <= bank_err[rd_bank];
        p1_n    <= rd_n;
        rd_k    <= k + cnt_t'(1);
      end
      if (rd_done) begin
        rd_state <= RD_IDLE;
        rd_bank  <= ~rd_bank;
      end else if (issue) begin
        rd_state <= RD_READ;
      end
    end
  end

  // Entries past an early eop were never written and read as zero.
  always_comb begin
    p1_beat     = '0;
    p1_beat.sop = p1_sop;
    p1_beat.eop = p1_eop;
    p1_beat.err = p1_err;
    p1_beat.n   = p1_n;
    p1_beat.re  = p1_zero ? '0 : rdata[2*DW-1:DW];
    p1_beat.im  = p1_zero ? '0 : rdata[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (pop) begin
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= p1_v;
        if (p1_v) skid_q <= p1_beat;
      end else begin
        out_v <= p1_v;
        if (p1_v) out_q <= p1_beat;
      end
    end else if (p1_v) begin
      if (!out_v) begin
        out_v <= 1'b1;
        out_q <= p1_beat;
      end else begin
        skid_v <= 1'b1;
        skid_q <= p1_beat;
      end
    end
  end

  assign source_valid = out_v;
  assign source_sop   = out_q.sop;
  assign source_eop   = out_q.eop;
  assign source_error = out_q.err;
  assign source_real  = out_q.re;
  assign source_imag  = out_q.im;
  assign fftpts_out   = out_q.n;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised bench for fft_bitrev_reorder against a frame-level model.
// Model collects accepted frames and lists the bit-reversed beats they must produce.
module tb_fft_bitrev_reorder;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sink_valid = 1'b0;
  logic          sink_ready;
  logic          sink_sop = 1'b0;
  logic          sink_eop = 1'b0;
  logic [1:0]    sink_error = 2'b00;
  logic [DW-1:0] sink_real = '0;
  logic [DW-1:0] sink_imag = '0;
  logic [10:0]   fftpts_in = '0;
  logic          source_valid;
  logic          source_ready = 1'b0;
  logic          source_sop;
  logic          source_eop;
  logic [1:0]    source_error;
  logic [DW-1:0] source_real;
  logic [DW-1:0] source_imag;
  logic [10:0]   fftpts_out;

  always #5 clk = ~clk;

  fft_bitrev_reorder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_error   (sink_error),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .fftpts_out   (fftpts_out)
  );

  typedef struct {
    int re;
    int im;
    bit sop;
    bit eop;
    int err;
    int n;
  } beat_t;

  beat_t exp_q[$];
  int    log_re[$];
  int    log_err[$];
  int    log_n[$];
  int    checks = 0;
  int    errors = 0;
  bit    rnd_valid = 0;
  bit    rnd_ready = 0;
  bit    chk_bubble = 0;

  bit    m_in = 0;
  bit    m_disc = 0;
  int    m_pend = 0;
  int    m_err = 0;
  int    m_n = 0;
  int    m_re[$];
  int    m_im[$];

  int    exp1[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int    exp5[8] = '{10, 14, 12, 0, 11, 0, 13, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_n(input int v);
    int n = 1;
    while (n * 2 <= v) n = n * 2;
    if (n < 8) n = 8;
    if (n > 1024) n = 1024;
    return n;
  endfunction

  function automatic int rev(input int kk, input int n);
    int j = 0;
    for (int b = 1; b < n; b = b * 2) j = j * 2 + ((kk / b) % 2);
    return j;
  endfunction

  function automatic void model_emit();
    beat_t b;
    for (int kk = 0; kk < m_n; kk++) begin
      int j = rev(kk, m_n);
      b.re  = (j < m_re.size()) ? m_re[j] : 0;
      b.im  = (j < m_im.size()) ? m_im[j] : 0;
      b.sop = (kk == 0);
      b.eop = (kk == m_n - 1);
      b.err = m_err;
      b.n   = m_n;
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_accept(input bit sop, input bit eop,
      input int err, input int re, input int im, input int pts);
    if (!m_in) begin
      if (sop) begin
        m_in = 1;
        m_disc = 0;
        m_n = model_n(pts);
        m_err = m_pend;
        m_pend = 0;
        m_re.delete();
        m_im.delete();
      end else if (!m_disc) begin
        m_pend = m_pend | 1;
      end
    end
    if (m_in) begin
      m_re.push_back(re);
      m_im.push_back(im);
      m_err = m_err | err;
      if (eop || m_re.size() == m_n) begin
        if (eop && m_re.size() < m_n) m_err = m_err | 3;
        else if (!eop) m_err = m_err | 2;
        model_emit();
        m_in = 0;
        m_disc = !eop;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && sink_valid && sink_ready)
      model_accept(sink_sop, sink_eop, int'(sink_error), int'(sink_real),
                   int'(sink_imag), int'(fftpts_in));
  end

  always @(posedge clk) begin
    #1;
    source_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  beat_t held;
  bit    stalled = 0;
  bit    in_out = 0;

  always @(negedge clk) begin
    beat_t x;
    if (!reset_n) begin
      stalled = 0;
      in_out = 0;
    end else begin
      if (stalled) begin
        checks++;
        if (!source_valid || source_sop != held.sop || source_eop != held.eop ||
            int'(source_error) != held.err || int'(source_real) != held.re ||
            int'(source_imag) != held.im || int'(fftpts_out) != held.n) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b re=%0d im=%0d expected re=%0d im=%0d",
                   source_valid, source_real, source_imag, held.re, held.im);
        end
      end
      if (chk_bubble && in_out) begin
        checks++;
        if (!source_valid) begin
          errors++;
          $display("FAIL bubble: got source_valid=0 expected 1 inside frame");
        end
      end
      if (source_valid && source_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got re=%0d expected no beat", source_real);
        end else begin
          x = exp_q.pop_front();
          if (int'(source_real) != x.re || int'(source_imag) != x.im ||
              source_sop != x.sop || source_eop != x.eop ||
              int'(source_error) != x.err || int'(fftpts_out) != x.n) begin
            errors++;
            $display("FAIL beat: got re=%0d im=%0d sop=%0b eop=%0b err=%0d n=%0d expected re=%0d im=%0d sop=%0b eop=%0b err=%0d n=%0d",
                     source_real, source_imag, source_sop, source_eop,
                     source_error, fftpts_out, x.re, x.im, x.sop, x.eop,
                     x.err, x.n);
          end
        end
        log_re.push_back(int'(source_real));
        log_err.push_back(int'(source_error));
        log_n.push_back(int'(fftpts_out));
        if (source_sop) in_out = 1;
        if (source_eop) in_out = 0;
      end
      stalled = source_valid && !source_ready;
      held.re  = int'(source_real);
      held.im  = int'(source_imag);
      held.sop = source_sop;
      held.eop = source_eop;
      held.err = int'(source_error);
      held.n   = int'(fftpts_out);
    end
  end

  task automatic send_beat(input int re, input int im, input bit sop,
      input bit eop, input int err, input int pts);
    bit done = 0;
    if (rnd_valid) begin
      while ($urandom_range(0, 1) == 1) begin
        sink_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    sink_real  = DW'(re);
    sink_imag  = DW'(im);
    sink_sop   = sop;
    sink_eop   = eop;
    sink_error = 2'(err);
    fftpts_in  = 11'(pts);
    sink_valid = 1'b1;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      done = sink_ready;
      @(posedge clk);
      #1;
    end
    sink_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL sink_timeout: got sink_ready=0 expected 1");
    end
  endtask

  task automatic send_frame(input int pts, input int nbeats, input int eop_at,
      input int base, input bit sop_first = 1, input bit rim = 0,
      input int ebeat = -1, input int eval = 0);
    for (int i = 0; i < nbeats; i++)
      send_beat((base + i) % 4096, rim ? int'($urandom_range(0, 4095)) : 0,
                sop_first && i == 0, i == eop_at, (i == ebeat) ? eval : 0, pts);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 8000) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic void clear_log();
    log_re.delete();
    log_err.delete();
    log_n.delete();
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sink_ready", int'(sink_ready), 0);
    check("rst_source_valid", int'(source_valid), 0);
    check("rst_sop_eop", int'({source_sop, source_eop}), 0);
    check("rst_error", int'(source_error), 0);
    check("rst_data", int'(source_real) + int'(source_imag), 0);
    check("rst_fftpts_out", int'(fftpts_out), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("sink_ready_after_reset", int'(sink_ready), 1);
    @(posedge clk);
    #1;

    clear_log();
    send_frame(8, 8, 7, 0);
    drain();
    check("t1_count", log_re.size(), 8);
    for (int i = 0; i < 8 && i < log_re.size(); i++)
      check($sformatf("t1_real_k%0d", i), log_re[i], exp1[i]);
    if (log_n.size() > 0) check("t1_fftpts", log_n[0], 8);
    if (log_err.size() > 0) check("t1_error", log_err[0], 0);

    clear_log();
    chk_bubble = 1;
    send_frame(16, 16, 15, 100);
    send_frame(16, 16, 15, 200);
    send_frame(16, 16, 15, 300);
    drain();
    chk_bubble = 0;
    check("t2_count", log_re.size(), 48);

    clear_log();
    send_frame(8, 8, 7, 0);
    send_frame(1024, 1024, 1023, 0);
    drain();
    check("t3_count", log_re.size(), 1032);
    if (log_re.size() > 9) begin
      check("t3_k1_index", log_re[9], 512);
      check("t3_fftpts", log_n[9], 1024);
    end

    clear_log();
    rnd_valid = 1;
    rnd_ready = 1;
    for (int f = 0; f < 6; f++)
      send_frame(int'($urandom_range(16, 31)), 16, 15,
                 int'($urandom_range(0, 4000)), 1, 1);
    drain();
    rnd_valid = 0;
    rnd_ready = 0;
    check("t4_count", log_re.size(), 96);

    clear_log();
    send_frame(8, 5, 4, 10);
    send_frame(8, 8, 7, 20);
    drain();
    check("t5_count", log_re.size(), 16);
    for (int i = 0; i < 8 && i < log_re.size(); i++)
      check($sformatf("t5_real_k%0d", i), log_re[i], exp5[i]);
    if (log_err.size() == 16) begin
      check("t5_err_first", log_err[0], 3);
      check("t5_err_last", log_err[7], 3);
      check("t5_next_err", log_err[8], 0);
    end

    clear_log();
    send_frame(8, 2, -1, 0, 0);
    send_frame(8, 8, 7, 30);
    send_frame(8, 10, -1, 40);
    send_frame(8, 3, -1, 0, 0);
    send_frame(8, 8, 7, 50, 1, 0, 3, 2);
    drain();
    check("t6_count", log_re.size(), 24);
    if (log_err.size() == 24) begin
      check("t6_missing_sop_err", log_err[0], 1);
      check("t6_missing_eop_err", log_err[8], 2);
      check("t6_sink_error_err", log_err[16], 2);
    end

    clear_log();
    send_frame(0, 8, 7, 60);
    send_frame(12, 8, 7, 70);
    drain();
    check("t7_count", log_re.size(), 16);
    if (log_n.size() == 16) begin
      check("t7_zero_pts", log_n[0], 8);
      check("t7_floor_pts", log_n[8], 8);
    end

    clear_log();
    send_frame(16, 5, -1, 80);
    reset_n = 1'b0;
    exp_q.delete();
    m_in = 0;
    m_disc = 0;
    m_pend = 0;
    @(negedge clk);
    check("t8_rst_sink_ready", int'(sink_ready), 0);
    check("t8_rst_source_valid", int'(source_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8, 8, 7, 90);
    drain();
    check("t8_count", log_re.size(), 8);
    if (log_re.size() > 1) check("t8_k1_real", log_re[1], 94);
    if (log_err.size() > 0) check("t8_err", log_err[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
